// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the PC enable/stall pair and the instruction-memory
// request, and counts fetches in flight so that responses still in flight when
// a redirect happens are dropped. It also handles halt, drain and resume.
// Optional stall-cycle counter is compiled in with `define FETCH_SEQUENCER_PERF_EN.
module fetch_sequencer #(
  parameter int MAXOUTSTANDING = 2,
  parameter int PERFBITWIDTH   = 16
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic clk_en,
  input  logic FetchReady,
  input  logic RespValid,
  input  logic IssueStall,
  input  logic RedirectEn,
  input  logic HaltReq,
  input  logic ResumeReq,
  output logic FetchReq,
  output logic PCEn,
  output logic StallEn,
  output logic InstrValid,
  output logic FlushOut,
  output logic Halted
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [PERFBITWIDTH-1:0] StallCycles
`endif
);

  localparam int            CW      = $clog2(MAXOUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAXOUTSTANDING);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  // Elaboration-time sanity check on the configuration.
  if (MAXOUTSTANDING < 1 || MAXOUTSTANDING > 7 || PERFBITWIDTH < 1) begin : g_param_chk
    $error("fetch_sequencer: MAXOUTSTANDING must be 1..7 and PERFBITWIDTH >= 1");
  end

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;

  logic active;       // cycle in which state may change
  logic below_limit;  // room for another fetch in flight
  logic fetch_base;   // RUN and nothing else blocking a fetch
  logic redirect;     // redirect that takes effect this cycle
  logic resp_live;    // response that actually retires an in-flight fetch
  logic accept;       // request handed to memory this cycle

  // Per-cycle qualifiers and the combinational outputs.
  always_comb begin
    active      = ~sync_rst & clk_en;
    below_limit = outstanding < MAX_OUT;
    fetch_base  = (state == RUN) & ~IssueStall & ~HaltReq & ~RedirectEn;
    redirect    = active & RedirectEn & (state != BOOT);
    // A response with nothing in flight (e.g. left over from before reset)
    // has no matching fetch and is ignored.
    resp_live   = active & RespValid & (outstanding != '0);

    FetchReq    = active & fetch_base & below_limit;
    accept      = FetchReq & FetchReady;
    PCEn        = accept | redirect;
    StallEn     = ~PCEn;
    FlushOut    = redirect;
    // The response arriving alongside a redirect belongs to the old path.
    InstrValid  = resp_live & (discard == '0) & ~redirect & (state != BOOT);
    Halted      = ~sync_rst & (state == HALTED);
  end

  // In-flight count: accept adds one, a live response retires one.
  always_comb begin
    outstanding_nxt = outstanding;
    unique case ({accept, resp_live})
      2'b10:   outstanding_nxt = outstanding + ONE;
      2'b01:   outstanding_nxt = outstanding - ONE;
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Discard count: a redirect marks everything still in flight as stale,
  // recomputed from the live count so repeated redirects never stack.
  always_comb begin
    discard_nxt = discard;
    if (redirect)
      discard_nxt = resp_live ? (outstanding - ONE) : outstanding;
    else if (resp_live && discard != '0)
      discard_nxt = discard - ONE;
  end

  // Control state: boot, run, drain toward halt, halted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!RedirectEn && HaltReq) state_nxt = DRAIN;
      DRAIN:   if (outstanding_nxt == '0) state_nxt = HALTED;
      HALTED:  if (ResumeReq && !HaltReq) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // State registers; clk_en low freezes everything.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= BOOT;
      outstanding <= '0;
      discard     <= '0;
    end else if (clk_en) begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

`ifdef FETCH_SEQUENCER_PERF_EN
  logic stall_hit;

  // A stall cycle is one where a fetch was wanted but memory was not ready
  // or the in-flight limit was reached.
  always_comb begin
    stall_hit = active & fetch_base & (~below_limit | ~FetchReady);
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (sync_rst)
      StallCycles <= '0;
    else if (stall_hit && !(&StallCycles))
      StallCycles <= StallCycles + {{(PERFBITWIDTH-1){1'b0}}, 1'b1};
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (MAXOUTSTANDING=2). Inputs change 1ns
// after the rising edge; outputs are checked 2ns later, well before the next edge.
module tb_fetch_sequencer;

  logic clk, sync_rst, clk_en, FetchReady, RespValid, IssueStall;
  logic RedirectEn, HaltReq, ResumeReq;
  logic FetchReq, PCEn, StallEn, InstrValid, FlushOut, Halted;
`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] StallCycles;
`endif

  int vec = 0;
  int err = 0;

  fetch_sequencer #(.MAXOUTSTANDING(2), .PERFBITWIDTH(16)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .FetchReady(FetchReady),
    .RespValid(RespValid), .IssueStall(IssueStall), .RedirectEn(RedirectEn),
    .HaltReq(HaltReq), .ResumeReq(ResumeReq), .FetchReq(FetchReq), .PCEn(PCEn),
    .StallEn(StallEn), .InstrValid(InstrValid), .FlushOut(FlushOut), .Halted(Halted)
`ifdef FETCH_SEQUENCER_PERF_EN
    , .StallCycles(StallCycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clk_en = 1'b1; FetchReady = 1'b0; RespValid = 1'b0; IssueStall = 1'b0;
    RedirectEn = 1'b0; HaltReq = 1'b0; ResumeReq = 1'b0;
  endtask

  task automatic test_reset();
    FetchReady = 1'b1; RespValid = 1'b1; RedirectEn = 1'b1; #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL rst_fetchreq got %b want 0", FetchReq); end
    vec++; if (PCEn !== 1'b0) begin err++; $display("FAIL rst_pcen got %b want 0", PCEn); end
    vec++; if (StallEn !== 1'b1) begin err++; $display("FAIL rst_stallen got %b want 1", StallEn); end
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL rst_instrvalid got %b want 0", InstrValid); end
    vec++; if (FlushOut !== 1'b0) begin err++; $display("FAIL rst_flush got %b want 0", FlushOut); end
    vec++; if (Halted !== 1'b0) begin err++; $display("FAIL rst_halted got %b want 0", Halted); end
    tick(); idle(); tick();
  endtask

  // Reset release, then one response each cycle after every accept.
  task automatic test_stream();
    sync_rst = 1'b0; FetchReady = 1'b1; #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL boot_fetchreq got %b want 0", FetchReq); end
    vec++; if (StallEn !== 1'b1) begin err++; $display("FAIL boot_stallen got %b want 1", StallEn); end
    tick();
    for (int c = 1; c <= 6; c++) begin
      RespValid = (c >= 2); #2;
      vec++; if (PCEn !== 1'b1) begin err++; $display("FAIL stream_pcen c%0d got %b want 1", c, PCEn); end
      vec++; if (InstrValid !== (c >= 2)) begin err++; $display("FAIL stream_ivalid c%0d got %b want %b", c, InstrValid, (c >= 2)); end
      tick();
    end
    FetchReady = 1'b0; IssueStall = 1'b1; RespValid = 1'b1; #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL stream_issuestall got %b want 0", FetchReq); end
    vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL stream_last_ivalid got %b want 1", InstrValid); end
    tick(); idle();
  endtask

  // Outstanding limit: two accepts, then blocked until a response returns.
  task automatic test_limit();
    FetchReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      vec++; if (PCEn !== (i < 2)) begin err++; $display("FAIL limit_pcen i%0d got %b want %b", i, PCEn, (i < 2)); end
      vec++; if (StallEn !== (i >= 2)) begin err++; $display("FAIL limit_stallen i%0d got %b want %b", i, StallEn, (i >= 2)); end
      tick();
    end
    RespValid = 1'b1; #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL limit_full_req got %b want 0", FetchReq); end
    vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL limit_resp got %b want 1", InstrValid); end
    tick(); RespValid = 1'b0; #2;
    vec++; if (PCEn !== 1'b1) begin err++; $display("FAIL limit_refill got %b want 1", PCEn); end
    tick(); #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL limit_full_again got %b want 0", FetchReq); end
    tick();
  endtask

  // Redirect with two in flight and no response that cycle.
  task automatic test_redirect();
    RedirectEn = 1'b1; #2;
    vec++; if (FlushOut !== 1'b1) begin err++; $display("FAIL redir_flush got %b want 1", FlushOut); end
    vec++; if (PCEn !== 1'b1) begin err++; $display("FAIL redir_pcen got %b want 1", PCEn); end
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL redir_fetchreq got %b want 0", FetchReq); end
    tick(); RedirectEn = 1'b0; FetchReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      RespValid = 1'b1; #2;
      vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL redir_drop%0d got %b want 0", i, InstrValid); end
      vec++; if (FlushOut !== 1'b0) begin err++; $display("FAIL redir_flush_clr%0d got %b want 0", i, FlushOut); end
      tick();
    end
    RespValid = 1'b0; FetchReady = 1'b1; tick();
    FetchReady = 1'b0; RespValid = 1'b1; #2;
    vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL redir_fresh got %b want 1", InstrValid); end
    tick(); idle();
  endtask

  // Redirect coincident with a response: one more stale response after it.
  task automatic test_redirect_resp();
    FetchReady = 1'b1; tick(); tick();
    FetchReady = 1'b0; RedirectEn = 1'b1; RespValid = 1'b1; #2;
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL rr_same_cycle got %b want 0", InstrValid); end
    vec++; if (FlushOut !== 1'b1) begin err++; $display("FAIL rr_flush got %b want 1", FlushOut); end
    tick(); RedirectEn = 1'b0; #2;
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL rr_drop got %b want 0", InstrValid); end
    tick(); RespValid = 1'b0; FetchReady = 1'b1; tick();
    FetchReady = 1'b0; RespValid = 1'b1; #2;
    vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL rr_fresh got %b want 1", InstrValid); end
    tick(); idle();
  endtask

  // Two redirects in a row must not double the discard count.
  task automatic test_back_to_back();
    FetchReady = 1'b1; tick(); tick();
    FetchReady = 1'b0; RedirectEn = 1'b1; tick(); #2;
    vec++; if (FlushOut !== 1'b1) begin err++; $display("FAIL b2b_flush2 got %b want 1", FlushOut); end
    tick(); RedirectEn = 1'b0; RespValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL b2b_drop%0d got %b want 0", i, InstrValid); end
      tick();
    end
    RespValid = 1'b0; FetchReady = 1'b1; tick();
    FetchReady = 1'b0; RespValid = 1'b1; #2;
    vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL b2b_fresh got %b want 1", InstrValid); end
    tick(); idle();
  endtask

  // Halt with two in flight, drain, halt/resume priority, resume.
  task automatic test_halt();
    FetchReady = 1'b1; tick(); tick();
    HaltReq = 1'b1; #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL halt_req_block got %b want 0", FetchReq); end
    vec++; if (PCEn !== 1'b0) begin err++; $display("FAIL halt_pcen got %b want 0", PCEn); end
    tick(); HaltReq = 1'b0; RespValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL drain_resp%0d got %b want 1", i, InstrValid); end
      vec++; if (Halted !== 1'b0) begin err++; $display("FAIL drain_halted%0d got %b want 0", i, Halted); end
      vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL drain_req%0d got %b want 0", i, FetchReq); end
      tick();
    end
    RespValid = 1'b0; #2;
    vec++; if (Halted !== 1'b1) begin err++; $display("FAIL halted got %b want 1", Halted); end
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL halted_req got %b want 0", FetchReq); end
    tick(); HaltReq = 1'b1; ResumeReq = 1'b1; tick();
    HaltReq = 1'b0; #2;
    vec++; if (Halted !== 1'b1) begin err++; $display("FAIL halt_priority got %b want 1", Halted); end
    tick(); ResumeReq = 1'b0; #2;
    vec++; if (Halted !== 1'b0) begin err++; $display("FAIL resume_halted got %b want 0", Halted); end
    vec++; if (FetchReq !== 1'b1) begin err++; $display("FAIL resume_req got %b want 1", FetchReq); end
    tick(); FetchReady = 1'b0; RespValid = 1'b1; #2;
    vec++; if (InstrValid !== 1'b1) begin err++; $display("FAIL resume_resp got %b want 1", InstrValid); end
    tick(); idle();
  endtask

  // clk_en low freezes the in-flight count and masks outputs.
  task automatic test_clk_en();
    FetchReady = 1'b1; tick();
    clk_en = 1'b0; RespValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      vec++; if (PCEn !== 1'b0) begin err++; $display("FAIL ce_pcen%0d got %b want 0", i, PCEn); end
      vec++; if (StallEn !== 1'b1) begin err++; $display("FAIL ce_stallen%0d got %b want 1", i, StallEn); end
      vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL ce_ivalid%0d got %b want 0", i, InstrValid); end
      tick();
    end
    clk_en = 1'b1; RespValid = 1'b0; #2;
    vec++; if (PCEn !== 1'b1) begin err++; $display("FAIL ce_resume_pcen got %b want 1", PCEn); end
    tick(); #2;
    vec++; if (FetchReq !== 1'b0) begin err++; $display("FAIL ce_count_held got %b want 0", FetchReq); end
    tick(); FetchReady = 1'b0; RespValid = 1'b1; tick(); tick(); #2;
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL ce_spurious_resp got %b want 0", InstrValid); end
    tick(); idle();
  endtask

  // Reset with fetches in flight: leftover responses are ignored.
  task automatic test_reset_midfetch();
    FetchReady = 1'b1; tick(); tick();
    sync_rst = 1'b1; FetchReady = 1'b0; RespValid = 1'b1; #2;
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL rstmid_rst got %b want 0", InstrValid); end
    tick(); sync_rst = 1'b0; #2;
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL rstmid_boot got %b want 0", InstrValid); end
    tick(); #2;
    vec++; if (InstrValid !== 1'b0) begin err++; $display("FAIL rstmid_stale got %b want 0", InstrValid); end
    tick(); idle();
  endtask

`ifdef FETCH_SEQUENCER_PERF_EN
  task automatic test_perf();
    sync_rst = 1'b1; tick(); #2;
    vec++; if (StallCycles !== 16'd0) begin err++; $display("FAIL perf_rst got %0d want 0", StallCycles); end
    sync_rst = 1'b0; tick();
    repeat (5) tick();
    IssueStall = 1'b1; #2;
    vec++; if (StallCycles !== 16'd5) begin err++; $display("FAIL perf_count got %0d want 5", StallCycles); end
    tick(); idle();
  endtask
`endif

  initial begin
    sync_rst = 1'b1;
    idle();
    tick(); tick();
    test_reset();
    test_stream();
    test_limit();
    test_redirect();
    test_redirect_resp();
    test_back_to_back();
    test_halt();
    test_clk_en();
    test_reset_midfetch();
`ifdef FETCH_SEQUENCER_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
